sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- W_ADDR_SIZE_BITS, 16, SRAM address width.
- W_DATA_BITS, 24, SRAM data width.
- WAIT_CYCLES, 9, extra cycles an access is held after its first cycle; an access occupies WAIT_CYCLES+1 cycles.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, reset; synchronous and active-high.
- req, in, 2, per-requester access request (bit 0 = reader, bit 1 = writer).
- we, in, 2, per-requester write select (1 = write, 0 = read).
- addr0 / addr1, in, W_ADDR_SIZE_BITS, per-requester address.
- wdata0 / wdata1, in, W_DATA_BITS, per-requester write data.
- gnt, out, 2, one-hot; marks the owner of the current access.
- done, out, 2, one-cycle completion pulse to the owner.
- rdata, out, W_DATA_BITS, captured read data, valid from the done pulse onward.
- busy, out, 1, high while an access is in flight.
- address, out, W_ADDR_SIZE_BITS, SRAM address.
- w_data, out, W_DATA_BITS, SRAM write data.
- r_data, in, W_DATA_BITS, SRAM read data.
- read_enable, out, 1, SRAM read strobe.
- write_enable, out, 1, SRAM write strobe.

Function
REQ-003 The block SHALL implement the states IDLE, ACCESS and COMPLETE.
REQ-004 In IDLE with any req bit high, the block SHALL pick a winner and move to ACCESS on the next edge, registering gnt, address, w_data and the enables.
REQ-005 Arbitration SHALL be round-robin:
- Single requester: it wins.
- Both requesting: the one not granted last wins.
- After reset, requester 0 has priority.
REQ-006 In ACCESS, address, w_data (writes only), and exactly one of read_enable/write_enable (per the winner's we) SHALL be held constant for exactly WAIT_CYCLES+1 cycles.
REQ-007 On the last ACCESS cycle, a read SHALL capture r_data into rdata; writes leave rdata unchanged.
REQ-008 COMPLETE SHALL last one cycle:
- Both enables low; gnt still asserted.
- done[owner] = 1 for that cycle only.
- Next state IDLE.
REQ-009 Latency from req sampled high in IDLE to the done pulse SHALL be WAIT_CYCLES+2 cycles. Back-to-back accesses SHALL be separated by one IDLE cycle, giving WAIT_CYCLES+3 cycles per access.
REQ-010 A requester SHALL hold req, we, addr and wdata stable from assertion until its done. The arbiter latches them at grant, so later changes SHALL NOT affect the access in flight.
REQ-011 If the owner drops req mid-ACCESS, the access SHALL still complete and done SHALL still pulse.
REQ-012 A requester keeping req high through done SHALL be treated as a new request in the following IDLE, subject to round-robin.
REQ-013 busy SHALL be 1 in ACCESS and COMPLETE, and 0 in IDLE.
REQ-014 gnt SHALL be zero in IDLE and never have more than one bit set.
REQ-015 read_enable and write_enable SHALL never be high simultaneously.
REQ-016 The wait count SHALL wrap from WAIT_CYCLES to 0 with no gap. WAIT_CYCLES=0 SHALL yield a one-cycle ACCESS.

Reset
REQ-017 While rst is high at a clock edge, the block SHALL enter IDLE and set:
- gnt = 0, done = 0, busy = 0
- read_enable = 0, write_enable = 0
- address = 0, w_data = 0, rdata = 0
- the last-granted pointer to favour requester 0.
REQ-018 Reset asserted mid-ACCESS SHALL abandon the access with no done pulse; the SRAM enables SHALL drop on that same edge.

Structure
REQ-019 The state enum arb_state_t and the default WAIT_CYCLES constant SHALL live in the shared package pixel_pkg.
REQ-020 The wait counter SHALL be one instance of the existing flex_counter, with:
- rollover_val = WAIT_CYCLES
- count_enable active in ACCESS
- clear asserted in IDLE
- rollover_flag marking the last ACCESS cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single read: req=01, we0=0, addr0=0x0010, r_data=0xABCDEF, WAIT_CYCLES=9 -> read_enable high 10 cycles with address=0x0010; done[0] pulses 11 cycles after req; rdata=0xABCDEF.
- Single write: req=10, we1=1, addr1=0x0200, wdata1=0x123456 -> write_enable high 10 cycles with w_data=0x123456; done[1] pulses once; rdata unchanged.
- Contention: req=11 held continuously after reset -> grants alternate 0,1,0,1; each done spaced 12 cycles apart.
- Mid-access drop: req0 deasserted in ACCESS cycle 3 -> access still runs 10 cycles; done[0] still pulses.
- Reset mid-access: rst in ACCESS cycle 5 -> next edge shows IDLE, enables 0, gnt=0, no done; after release, req=11 grants requester 0 first.

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared state encoding and timing defaults for the SRAM arbiter.
package pixel_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} arb_state_t;
  localparam int DEFAULT_WAIT_CYCLES = 9;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter wrapping from rollover_val to 0, flagging the final count.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] r_count;
  assign rollover_flag = r_count == rollover_val;
  always_ff @(posedge clk) begin
    if (rst || clear) r_count <= '0;
    else if (count_enable) r_count <= rollover_flag ? '0 : r_count + 1'b1;
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one SRAM between a reader and a writer port.
module sram_arbiter
  import pixel_pkg::*;
#(
  parameter int W_ADDR_SIZE_BITS = 16,
  parameter int W_DATA_BITS      = 24,
  parameter int WAIT_CYCLES      = DEFAULT_WAIT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req,
  input  logic [1:0]                  we,
  input  logic [W_ADDR_SIZE_BITS-1:0] addr0,
  input  logic [W_ADDR_SIZE_BITS-1:0] addr1,
  input  logic [W_DATA_BITS-1:0]      wdata0,
  input  logic [W_DATA_BITS-1:0]      wdata1,
  output logic [1:0]                  gnt,
  output logic [1:0]                  done,
  output logic [W_DATA_BITS-1:0]      rdata,
  output logic                        busy,
  output logic [W_ADDR_SIZE_BITS-1:0] address,
  output logic [W_DATA_BITS-1:0]      w_data,
  input  logic [W_DATA_BITS-1:0]      r_data,
  output logic                        read_enable,
  output logic                        write_enable
);
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  arb_state_t r_state, w_next;
  logic [1:0] r_gnt;
  logic r_last, r_wr, w_win, w_roll;
  logic [W_ADDR_SIZE_BITS-1:0] r_addr;
  logic [W_DATA_BITS-1:0] r_wdata, r_rdata;
  // r_last names the previous winner; with both requesting, the other side wins
  assign w_win = (req == 2'b11) ? ~r_last : req[1];
  assign gnt = r_gnt;
  assign rdata = r_rdata;
  assign address = r_addr;
  assign w_data = r_wdata;
  flex_counter #(.NUM_CNT_BITS(CW)) u_wait (
    .clk(clk),
    .rst(rst),
    .clear(r_state == IDLE),
    .count_enable(r_state == ACCESS),
    .rollover_val(CW'(WAIT_CYCLES)),
    .rollover_flag(w_roll)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    done = 2'b00;
    busy = r_state != IDLE;
    read_enable = 1'b0;
    write_enable = 1'b0;
    w_next = (r_state == IDLE) ? (|req ? ACCESS : IDLE) : (r_state == ACCESS) ? (w_roll ? COMPLETE : ACCESS) : IDLE;
    done = (r_state == COMPLETE) ? r_gnt : 2'b00;
    read_enable = (r_state == ACCESS) && !r_wr;
    write_enable = (r_state == ACCESS) && r_wr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= '0;
      r_last <= 1'b1;
      r_wr <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && |req) begin
        r_gnt <= w_win ? 2'b10 : 2'b01;
        r_last <= w_win;
        r_wr <= we[w_win];
        r_addr <= w_win ? addr1 : addr0;
        if (we[w_win]) r_wdata <= w_win ? wdata1 : wdata0;
      end
      if (r_state == ACCESS && w_roll && !r_wr) r_rdata <= r_data;
      if (r_state == COMPLETE) r_gnt <= '0;
    end
  end
endmodule
